mul_div_unit_32: RTL and testbench
==================================

Name: mul_div_unit_32

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Accepts two 32-bit operands plus the RV32M funct3 code, computes one bit per cycle, and presents the 32-bit result with a one-cycle DONE strobe.
- Directly upstream of the 32-bit execute-result pipeline register: RESULT feeds that register's D input, gated by DONE.
- Fixed, data-independent latency; the control unit can stall deterministically.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RES  in  1  reset; synchronous, active-high.
- START  in  1  request; sampled only when the unit is idle.
- FUNCT3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  32  rs1 operand.
- B  in  32  rs2 operand.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse; RESULT is valid in this cycle.
- RESULT  out  32  result; held until the next accepted START completes.

Behaviour:
- Reset: RES=1 at an edge forces state IDLE, BUSY=0, DONE=0, RESULT=0, and clears counter and internal registers. This applies from any state; an operation in flight is abandoned with no DONE. START in a reset cycle is ignored.
- States: IDLE, CALC, FINISH.
- IDLE:
  - START=1 at edge k: latch FUNCT3, sign flags and operand magnitudes, clear the 64-bit accumulator and counter, go to CALC.
  - Signedness: A is signed for MULH, MULHSU, DIV and REM. B is signed for MULH, DIV and REM. MUL uses low bits, so signedness is irrelevant.
- CALC: one iteration per edge, 32 edges (k+1..k+32). The counter increments each edge; leave CALC when counter = 31.
  - Multiply: shift-add on magnitudes. If the multiplier LSB is 1, add the multiplicand to the upper half of the 65-bit {carry, acc}, then shift right by 1.
  - Divide: restoring division on magnitudes. Shift the remainder/quotient left by 1, trial-subtract the divisor with a 33-bit subtract. If non-negative, keep the difference and set quotient bit 1; otherwise set 0.
- FINISH (edge k+33):
  - Apply sign correction: negate the 64-bit product if the operand signs differ. Negate the quotient if the signs differ; the remainder takes the sign of A.
  - Select the output: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register RESULT, set DONE=1 for the following cycle, return to IDLE.
- Latency: DONE is high in the cycle after edge k+33, i.e. 34 cycles after the START sample edge.
- Special cases: computed by override at FINISH; latency is unchanged.
  - Divide by zero (B=0): DIV/DIVU = 0xFFFFFFFF; REM/REMU = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- BUSY: 1 in all cycles while in CALC or FINISH; 0 in IDLE, including the DONE cycle.
- START while BUSY=1 is ignored, with no queueing. Operands and FUNCT3 may change freely after acceptance.
- Back-to-back: START in the DONE cycle is accepted. RESULT keeps the old value until the new FINISH.
- DONE and BUSY are never both 1.

Decomposition:
- Shared package holds:
  - FUNCT3 localparams for the eight RV32M codes.
  - State encoding (IDLE=2'd0, CALC=2'd1, FINISH=2'd2).
  - Constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Single module. No sub-module is needed; the 33-bit add/subtract stays inline.

Test Plan:
1. MUL A=7, B=6, START pulse → BUSY=1 for 33 cycles, DONE 34 cycles after START, RESULT=42.
2. MULH A=0xFFFFFFFF (-1), B=0xFFFFFFFF → RESULT=0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU A=-1, B=2 → 0xFFFFFFFF.
3. DIV A=-7, B=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU A=100, B=7 → 14. REMU → 2.
4. Special cases: DIVU A=5, B=0 → 0xFFFFFFFF; REM A=5, B=0 → 5; DIV A=0x80000000, B=-1 → 0x80000000; REM with the same operands → 0. Latency is still 34 in every case.
5. START asserted at cycle 10 mid-operation is ignored (result unchanged). START in the DONE cycle starts a second op; RESULT holds the first value until the second DONE.
6. RES asserted at CALC iteration 15 → next cycle BUSY=0, DONE=0, RESULT=0. No DONE ever follows; a new START then completes normally.

Source files
------------

// File: rtl/mul_div_unit_32_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mul_div_unit_32_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_unit_32.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes,
// sign fix-up and special-case override in a final cycle; fixed 34-cycle latency.
module mul_div_unit_32
  import mul_div_unit_32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  state_t state, next_state;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic              neg_a, neg_b, b_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   work;
  logic [2*XLEN-1:0] acc;

  logic            a_signed, b_signed, is_div;
  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, rem, a_orig, result_sel;

  always_ff @(posedge CLK) begin
    if (RES) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (START) next_state = CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_comb begin
    a_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
               (FUNCT3 == F3_DIV)  || (FUNCT3 == F3_REM);
    b_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    is_div   = f3[2];

    // Multiply: multiplicand is |A|, multiplier bits shift out of work LSB-first.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, mag_a} : '0);
    // Divide: dividend bits shift out of work MSB-first into the remainder.
    rem_sh  = {acc[2*XLEN-1:XLEN], work[XLEN-1]};
    diff    = rem_sh - {1'b0, mag_b};

    prod   = (neg_a ^ neg_b) ? -acc : acc;
    quot   = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    a_orig = neg_a ? -mag_a : mag_a;

    result_sel = '0;
    case (f3)
      F3_MUL:                        result_sel = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result_sel = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (b_zero)                  result_sel = DIV0_QUOT;
        else if (ovf && f3 == F3_DIV) result_sel = INT_MIN;
        else                         result_sel = quot;
      end
      default: begin
        if (b_zero)                  result_sel = a_orig;
        else if (ovf && f3 == F3_REM) result_sel = '0;
        else                         result_sel = rem;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt    <= '0;
      f3     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      work   <= '0;
      acc    <= '0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        // IDLE: capture operation, signs and magnitudes
        IDLE: if (START) begin
          f3     <= FUNCT3;
          neg_a  <= a_signed & A[XLEN-1];
          neg_b  <= b_signed & B[XLEN-1];
          mag_a  <= (a_signed & A[XLEN-1]) ? -A : A;
          mag_b  <= (b_signed & B[XLEN-1]) ? -B : B;
          work   <= (b_signed & B[XLEN-1]) ? -B : B;
          b_zero <= (B == '0);
          ovf    <= (A == INT_MIN) && (B == '1);
          acc    <= '0;
          cnt    <= '0;
          if (FUNCT3[2]) work <= (a_signed & A[XLEN-1]) ? -A : A;
        end
        // CALC: one shift-add or restoring-divide step per cycle
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            work <= {work[XLEN-2:0], 1'b0};
            if (!diff[XLEN]) acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else             acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          end else begin
            work <= {1'b0, work[XLEN-1:1]};
            acc  <= {mul_sum, acc[XLEN-1:1]};
          end
        end
        // FINISH: sign correction, special cases, output register
        FINISH: begin
          RESULT <= result_sel;
          DONE   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit_32.sv
// Directed-vector bench for mul_div_unit_32 with hand-computed results.
module tb_mul_div_unit_32;

  logic        CLK = 1'b0;
  logic        RES;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] A, B;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit_32 dut (
    .CLK(CLK), .RES(RES), .START(START), .FUNCT3(FUNCT3),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits on falling edges until DONE; n=1 is the first falling edge after the START edge.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (BUSY) busy_n++;
    end while (!DONE && n < 100);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    FUNCT3 = f; A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678; FUNCT3 = 3'b000;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n, busy_n;
    @(negedge CLK);
    issue(f, a, b);
    wait_done(n, busy_n);
    check({tag, "_result"}, RESULT, exp);
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
    check({tag, "_busy_in_done"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int n, busy_n;
    bit seen_done;
    RES = 1'b1; START = 1'b1; FUNCT3 = 3'b000; A = 32'd3; B = 32'd4;
    repeat (3) @(posedge CLK);
    #1 RES = 1'b0; START = 1'b0;
    @(negedge CLK);
    check("reset_result", RESULT, 32'h0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);

    run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42);
    run_op("mul_neg",     3'b000, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFF1);
    run_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF);
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF);
    run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14);
    run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2);
    run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF);
    run_op("rem_by0",     3'b110, 32'd5,        32'd0,        32'd5);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // START mid-operation ignored; START in DONE cycle accepted back-to-back.
    @(negedge CLK);
    issue(3'b000, 32'd7, 32'd6);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 10) begin START = 1'b1; FUNCT3 = 3'b101; A = 32'd99; B = 32'd3; end
      if (n == 11) START = 1'b0;
    end while (!DONE && n < 100);
    check("ignore_start_result", RESULT, 32'd42);
    check("ignore_start_latency", 32'(n), 32'd34);
    START = 1'b1; FUNCT3 = 3'b101; A = 32'd100; B = 32'd7;
    @(posedge CLK);
    #1 START = 1'b0; A = 32'd0; B = 32'd0;
    @(negedge CLK);
    check("b2b_busy", {31'd0, BUSY}, 32'd1);
    check("b2b_hold_early", RESULT, 32'd42);
    repeat (20) @(negedge CLK);
    check("b2b_hold_mid", RESULT, 32'd42);
    n = 21;
    while (!DONE && n < 100) begin @(negedge CLK); n++; end
    check("b2b_result", RESULT, 32'd14);
    check("b2b_latency", 32'(n), 32'd34);

    // Reset in flight abandons the operation.
    @(negedge CLK);
    issue(3'b000, 32'd7, 32'd6);
    repeat (15) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    check("abort_result", RESULT, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE || BUSY) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    run_op("after_abort", 3'b000, 32'd1000, 32'd1000, 32'd1000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
